// File: rtl/seg7_time_scanner.sv
// -----------------------------------------------------------------------------
// seg7_time_scanner
//
// Shows the clock core's HH:MM on the low four digits of the board's
// time-multiplexed, active-low 7-segment display. Once per refresh frame the
// hour and minute are snapshotted. A sequential subtract-by-10 engine splits
// each value into BCD tens/ones. All four digits are then committed together,
// so an hour/minute pair is never shown half-updated.
//
// Handshake: none. The inputs are level signals that are sampled in the LOAD
// state. The outputs are free-running, registered scan signals.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 4)
//   BLANK_LZ  1 = blank the hour-tens digit when it is 0
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous reset, active-high
//   hour_i      binary hours   (0..23; larger values show "--")
//   min_i       binary minutes (0..59; larger values show "--")
//   colon_i     1 = light the DP on digit 2, sampled live
//   led7_seg_o  segments, active-low, {dp,g,f,e,d,c,b,a}
//   led7_an_o   digit anodes, active-low, bits 7:4 always 1
// -----------------------------------------------------------------------------
module seg7_time_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] hour_i,
   input  logic [5:0] min_i,
   input  logic       colon_i,
   output logic [7:0] led7_seg_o,
   output logic [7:0] led7_an_o
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   // Digit code outside 0..9 that renders as a dash.
   localparam logic [3:0] DASH = 4'hA;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_CONV_H,
      ST_CONV_M,
      ST_COMMIT,
      ST_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
   logic [1:0]      dig_idx_q, dig_idx_d;
   logic [5:0]      hour_val_q, hour_val_d;
   logic [5:0]      min_val_q, min_val_d;
   logic [2:0]      hour_tens_q, hour_tens_d;
   logic [2:0]      min_tens_q, min_tens_d;
   logic            hour_bad_q, hour_bad_d;
   logic            min_bad_q, min_bad_d;
   logic [3:0]      disp_q [4];
   logic [3:0]      disp_d [4];
   logic [7:0]      seg_q, seg_d;
   logic [7:0]      an_q, an_d;
   logic            scan_wrap;
   logic            frame_start;
   logic [3:0]      cur_dig;

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'h40;
         4'd1:    enc = 7'h79;
         4'd2:    enc = 7'h24;
         4'd3:    enc = 7'h30;
         4'd4:    enc = 7'h19;
         4'd5:    enc = 7'h12;
         4'd6:    enc = 7'h02;
         4'd7:    enc = 7'h78;
         4'd8:    enc = 7'h00;
         4'd9:    enc = 7'h10;
         default: enc = 7'h3F;
      endcase
   endfunction

   // Scan timing
   always_comb begin
      scan_wrap   = (scan_cnt_q == CNT_LAST);
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      dig_idx_d   = scan_wrap ? dig_idx_q + 2'd1 : dig_idx_q;
      frame_start = scan_wrap && (dig_idx_q == 2'd3);
   end

   // Snapshot / conversion FSM
   always_comb begin
      state_d     = state_q;
      hour_val_d  = hour_val_q;
      min_val_d   = min_val_q;
      hour_tens_d = hour_tens_q;
      min_tens_d  = min_tens_q;
      hour_bad_d  = hour_bad_q;
      min_bad_d   = min_bad_q;
      disp_d      = disp_q;
      case (state_q)
         ST_LOAD: begin
            // Out-of-range values load as 0 so the conversion stays short;
            // the bad flag replaces the digits with dashes at commit.
            hour_bad_d  = (hour_i > 6'd23);
            min_bad_d   = (min_i > 6'd59);
            hour_val_d  = (hour_i > 6'd23) ? 6'd0 : hour_i;
            min_val_d   = (min_i > 6'd59) ? 6'd0 : min_i;
            hour_tens_d = 3'd0;
            min_tens_d  = 3'd0;
            state_d     = ST_CONV_H;
         end
         ST_CONV_H: begin
            if (hour_val_q >= 6'd10) begin
               hour_val_d  = hour_val_q - 6'd10;
               hour_tens_d = hour_tens_q + 3'd1;
            end else begin
               state_d = ST_CONV_M;
            end
         end
         ST_CONV_M: begin
            if (min_val_q >= 6'd10) begin
               min_val_d  = min_val_q - 6'd10;
               min_tens_d = min_tens_q + 3'd1;
            end else begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            disp_d[0] = min_bad_q  ? DASH : min_val_q[3:0];
            disp_d[1] = min_bad_q  ? DASH : {1'b0, min_tens_q};
            disp_d[2] = hour_bad_q ? DASH : hour_val_q[3:0];
            disp_d[3] = hour_bad_q ? DASH : {1'b0, hour_tens_q};
            state_d   = ST_IDLE;
         end
         ST_IDLE: begin
            if (frame_start) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Output stage; the anodes stay dark on count 0 of each slot so the
   // segment change never ghosts onto the neighbouring digit.
   always_comb begin
      cur_dig    = disp_q[dig_idx_q];
      seg_d      = {~((dig_idx_q == 2'd2) && colon_i), enc(cur_dig)};
      if (BLANK_LZ && (dig_idx_q == 2'd3) && (cur_dig == 4'd0)) begin
         seg_d[6:0] = 7'h7F;
      end
      an_d = 8'hFF;
      if (scan_cnt_q != '0) begin
         an_d[dig_idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_LOAD;
         scan_cnt_q  <= '0;
         dig_idx_q   <= 2'd0;
         hour_val_q  <= 6'd0;
         min_val_q   <= 6'd0;
         hour_tens_q <= 3'd0;
         min_tens_q  <= 3'd0;
         hour_bad_q  <= 1'b0;
         min_bad_q   <= 1'b0;
         for (int i = 0; i < 4; i++) disp_q[i] <= 4'd0;
         seg_q       <= 8'hFF;
         an_q        <= 8'hFF;
      end else begin
         state_q     <= state_d;
         scan_cnt_q  <= scan_cnt_d;
         dig_idx_q   <= dig_idx_d;
         hour_val_q  <= hour_val_d;
         min_val_q   <= min_val_d;
         hour_tens_q <= hour_tens_d;
         min_tens_q  <= min_tens_d;
         hour_bad_q  <= hour_bad_d;
         min_bad_q   <= min_bad_d;
         for (int i = 0; i < 4; i++) disp_q[i] <= disp_d[i];
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign led7_seg_o = seg_q;
   assign led7_an_o  = an_q;

endmodule
